// File: rtl/trigger_phase_capture.sv
// Trigger pulse phase/width checker: measures BSYNC-to-rise offset and pulse width per pulse.
// Optional report/error counters are built when TRIG_CAPTURE_STATS_EN is defined.
module trigger_phase_capture #(
  parameter int CNT_WIDTH = 16,
  parameter int TOL_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cap_en,
  input  logic                 trig_in,
  input  logic                 bsync_event,
  input  logic                 bsync_ready,
  input  logic [CNT_WIDTH-1:0] bsync_ratio,
  input  logic [CNT_WIDTH-1:0] expected_phase,
  input  logic [TOL_WIDTH-1:0] phase_tol,
  output logic                 phase_valid,
  output logic [CNT_WIDTH-1:0] phase_value,
  output logic [CNT_WIDTH-1:0] width_value,
  output logic                 width_err,
  output logic                 align_err,
  output logic                 timeout,
  output logic [2:0]           cap_state,
  output logic [31:0]          cap_count,
  output logic [31:0]          err_count
);

  localparam int W1 = CNT_WIDTH + 1;
  localparam logic [CNT_WIDTH-1:0] ONE    = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] ALL1   = '1;
  localparam logic [W1-1:0]        ONE_W1 = {{CNT_WIDTH{1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARMED   = 3'd1,
    S_MEASURE = 3'd2,
    S_WIDTH   = 3'd3,
    S_REPORT  = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic                  trig_q;
  logic [CNT_WIDTH-1:0]  phase_cnt_q, phase_cnt_d;
  logic [CNT_WIDTH-1:0]  width_cnt_q, width_cnt_d;
  logic [CNT_WIDTH-1:0]  phase_lat_q, phase_lat_d;
  logic [CNT_WIDTH-1:0]  width_lat_q, width_lat_d;
  logic                  ovf_q, ovf_d;
  logic                  valid_q, valid_d;
  logic                  timeout_q, timeout_d;
  logic [CNT_WIDTH-1:0]  phase_val_q, phase_val_d;
  logic [CNT_WIDTH-1:0]  width_val_q, width_val_d;
  logic                  werr_q, werr_d;
  logic                  aerr_q, aerr_d;

  logic                  rise, fall, run_ok;
  logic [W1-1:0]         win, pdiff, pmag;

  assign rise   = trig_in & ~trig_q;
  assign fall   = ~trig_in & trig_q;
  assign run_ok = cap_en & bsync_ready;
  // Window is 2*ratio held one bit wider so it never wraps.
  assign win    = {bsync_ratio, 1'b0};
  assign pdiff  = {1'b0, phase_lat_q} - {1'b0, expected_phase};
  assign pmag   = pdiff[W1-1] ? ({1'b0, expected_phase} - {1'b0, phase_lat_q}) : pdiff;

  always_comb begin
    state_d     = state_q;
    phase_cnt_d = phase_cnt_q;
    width_cnt_d = width_cnt_q;
    phase_lat_d = phase_lat_q;
    width_lat_d = width_lat_q;
    ovf_d       = ovf_q;
    valid_d     = 1'b0;
    timeout_d   = 1'b0;
    phase_val_d = phase_val_q;
    width_val_d = width_val_q;
    werr_d      = werr_q;
    aerr_d      = aerr_q;
    if (state_q != S_IDLE && !run_ok) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (run_ok) state_d = S_ARMED;
        S_ARMED: begin
          if (bsync_event) begin
            phase_cnt_d = '0;
            state_d     = S_MEASURE;
          end
        end
        S_MEASURE: begin
          if (rise) begin
            phase_lat_d = phase_cnt_q;
            width_cnt_d = ONE;
            ovf_d       = 1'b0;
            state_d     = S_WIDTH;
          end else if ({1'b0, phase_cnt_q} == win - ONE_W1) begin
            timeout_d = 1'b1;
            state_d   = S_ARMED;
          end else if (phase_cnt_q != ALL1) begin
            phase_cnt_d = phase_cnt_q + ONE;
          end
        end
        S_WIDTH: begin
          if (fall) begin
            width_lat_d = width_cnt_q;
            state_d     = S_REPORT;
          end else if ({1'b0, width_cnt_q} == win) begin
            width_lat_d = win[CNT_WIDTH-1:0];
            ovf_d       = 1'b1;
            state_d     = S_REPORT;
          end else if (width_cnt_q != ALL1) begin
            width_cnt_d = width_cnt_q + ONE;
          end
        end
        S_REPORT: begin
          valid_d     = 1'b1;
          phase_val_d = phase_lat_q;
          width_val_d = width_lat_q;
          werr_d      = ovf_q | (width_lat_q != bsync_ratio);
          aerr_d      = pmag > {{(W1-TOL_WIDTH){1'b0}}, phase_tol};
          state_d     = S_ARMED;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      trig_q      <= 1'b0;
      phase_cnt_q <= '0;
      width_cnt_q <= '0;
      phase_lat_q <= '0;
      width_lat_q <= '0;
      ovf_q       <= 1'b0;
      valid_q     <= 1'b0;
      timeout_q   <= 1'b0;
      phase_val_q <= '0;
      width_val_q <= '0;
      werr_q      <= 1'b0;
      aerr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      trig_q      <= trig_in;
      phase_cnt_q <= phase_cnt_d;
      width_cnt_q <= width_cnt_d;
      phase_lat_q <= phase_lat_d;
      width_lat_q <= width_lat_d;
      ovf_q       <= ovf_d;
      valid_q     <= valid_d;
      timeout_q   <= timeout_d;
      phase_val_q <= phase_val_d;
      width_val_q <= width_val_d;
      werr_q      <= werr_d;
      aerr_q      <= aerr_d;
    end
  end

  assign phase_valid = valid_q;
  assign phase_value = phase_val_q;
  assign width_value = width_val_q;
  assign width_err   = werr_q;
  assign align_err   = aerr_q;
  assign timeout     = timeout_q;
  assign cap_state   = state_q;

`ifdef TRIG_CAPTURE_STATS_EN
  logic [31:0] cap_cnt_q, err_cnt_q;

  // Counters follow the registered strobes, so they settle one cycle after each report.
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      if (valid_q && cap_cnt_q != 32'hFFFF_FFFF) cap_cnt_q <= cap_cnt_q + 32'd1;
      if (((valid_q && (werr_q || aerr_q)) || timeout_q) && err_cnt_q != 32'hFFFF_FFFF)
        err_cnt_q <= err_cnt_q + 32'd1;
    end
  end

  assign cap_count = cap_cnt_q;
  assign err_count = err_cnt_q;
`else
  assign cap_count = '0;
  assign err_count = '0;
`endif

endmodule

// File: doc/trigger_phase_capture.md
Name: trigger_phase_capture

Overview:
- Receive-side checker for the aligned trigger pulses produced by the ADF4030 trigger channels.
- Measures the delay, in clk cycles, from a BSYNC event to the rising edge of an incoming trigger pulse, and measures the pulse's high width.
- Reports both measurements once per pulse, with flags for width mismatch, phase misalignment and missing pulse.
- Used in loopback/self-test paths to confirm channel phase programming against the expected value.

Parameters:
- CNT_WIDTH, 16: width of the phase/width counters and of bsync_ratio, expected_phase and the result fields.
- TOL_WIDTH, 8: width of the phase_tol input.

Ports:
- clk  in  1  core clock; all logic in this single clock domain.
- rst  in  1  synchronous, active-high reset.
- cap_en  in  1  capture enable.
- trig_in  in  1  trigger pulse under test, synchronous to clk.
- bsync_event  in  1  single-cycle BSYNC reference marker.
- bsync_ready  in  1  BSYNC alignment valid.
- bsync_ratio  in  CNT_WIDTH  expected pulse width in cycles; the window is 2*bsync_ratio.
- expected_phase  in  CNT_WIDTH  expected rise offset after bsync_event.
- phase_tol  in  TOL_WIDTH  allowed |phase error|.
- phase_valid  out  1  one-cycle result strobe.
- phase_value  out  CNT_WIDTH  measured rise offset.
- width_value  out  CNT_WIDTH  measured high width.
- width_err  out  1  width_value != bsync_ratio, or width overflow.
- align_err  out  1  |phase_value - expected_phase| > phase_tol.
- timeout  out  1  one-cycle strobe: no rise within the window.
- cap_state  out  3  current FSM state.
- cap_count  out  32  reports issued (optional feature).
- err_count  out  32  reports with any error, plus timeouts (optional feature).

Behaviour:
- Reset (rst=1 at a clk edge):
  - State goes to IDLE; trig_d is cleared.
  - All outputs and counters are 0.
  - Reset mid-operation aborts silently, with no strobe.
- Edge detect:
  - trig_d <= trig_in every cycle.
  - rise = trig_in & ~trig_d; fall = ~trig_in & trig_d.
- Window: win = 2*bsync_ratio, evaluated at CNT_WIDTH+1 bits (no overflow).
- Global abort: if cap_en=0 or bsync_ready=0 in any non-IDLE state, the next state is IDLE, with no strobe and no report.
- IDLE (0):
  - Go to ARMED when cap_en and bsync_ready are both 1.
- ARMED (1):
  - On bsync_event: go to MEASURE and load phase_cnt=0.
  - A rise in the same cycle as bsync_event is ignored.
- MEASURE (2):
  - If rise: latch phase_cnt, load width_cnt=1, go to WIDTH. A rise in the first MEASURE cycle gives phase 0.
  - Else if phase_cnt == win-1: pulse timeout for 1 cycle (registered), go to ARMED.
  - Else: phase_cnt+1.
  - bsync_event while in MEASURE is ignored.
- WIDTH (3):
  - If fall: latch width_cnt, go to REPORT.
  - Else if width_cnt == win: set overflow, latch win, go to REPORT.
  - Else: width_cnt+1.
- REPORT (4):
  - phase_valid=1 for exactly one cycle.
  - phase_value, width_value, width_err and align_err are registered, and hold until the next report.
  - align_err uses a CNT_WIDTH+1-bit signed difference compared with zero-extended phase_tol.
  - Go to ARMED. A bsync_event in this cycle is missed.
- Latency:
  - phase_valid asserts 2 cycles after the cycle trig_in first reads low (fall detected, then REPORT registers).
  - timeout asserts 1 cycle after the terminal MEASURE cycle.
- bsync_ratio=0: win=0, so the terminal check is never hit. MEASURE and WIDTH saturate at all-ones without wrap.
- cap_state values 5..7 are illegal and return to IDLE.

Optional Feature:
- Macro: TRIG_CAPTURE_STATS_EN.
- Defined:
  - cap_count increments on each phase_valid.
  - err_count increments on each phase_valid with width_err|align_err, and on each timeout.
  - Both saturate at 0xFFFFFFFF and clear on rst.
- Undefined: the counter logic is absent; cap_count and err_count are tied to 0.

Test Plan:
- bsync_ratio=4, expected_phase=3, phase_tol=0; rise 4 cycles after bsync_event (3 cycles in MEASURE), high 4 cycles -> phase_valid once, phase_value=3, width_value=4, width_err=0, align_err=0.
- Same setup, pulse high 5 cycles, rise at offset 5, phase_tol=1 -> width_value=5, width_err=1, phase_value=5, align_err=1.
- bsync_ratio=4, no pulse after bsync_event -> timeout strobe after 8 MEASURE cycles, no phase_valid; state returns to ARMED (1).
- bsync_ratio=3, trig_in held high after rise -> width_value=6, width_err=1 at width overflow.
- cap_en dropped while in WIDTH -> cap_state=0 next cycle, no phase_valid; rst pulsed mid-MEASURE -> all outputs 0.
- With TRIG_CAPTURE_STATS_EN, run 3 good reports, 1 bad report and 1 timeout -> cap_count=4, err_count=2. Without the macro, both read 0.
